sine_phase_sequencer: RTL and testbench

SINE_PHASE_SEQUENCER -- requirements
Module: sine_phase_sequencer

---
 rtl/sine_phase_sequencer_pkg.sv | 19 +
 rtl/sine_phase_sequencer_if.sv | 36 +++
 rtl/sine_phase_sequencer.sv | 100 ++++++++++
 tb/tb_sine_phase_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_phase_sequencer_pkg.sv
// Shared constants for the sine phase sequencer: FSM encoding, CORDIC seed,
// WAIT timeout limit, accumulator width and the quadrant-fold helper.
package sine_phase_sequencer_pkg;

   localparam int ACC_W = 16;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   localparam logic [7:0] X_GAIN        = 8'sd77;
   localparam logic [3:0] TIMEOUT_LIMIT = 4'd15;

   // Quadrants 2 and 3 are mirrored about pi/2 so the CORDIC angle stays in [-pi/2, pi/2].
   function automatic logic [7:0] fold_phase(input logic [7:0] p);
      return (p[7] ^ p[6]) ? 8'd128 - p : p;
   endfunction

endpackage

// File: rtl/sine_phase_sequencer_if.sv
// Request, CORDIC and sample/status signals of the sine phase sequencer.
// The slave modport is the sequencer; the master modport is the surrounding logic.
interface sine_phase_sequencer_if;

   logic       sample_tick_i;
   logic       enable_i;
   logic [15:0] freq_word_i;
   logic       phase_clear_i;
   logic       clear_flags_i;
   logic [7:0] cordic_x_o;
   logic [7:0] cordic_y_o;
   logic [7:0] cordic_z_o;
   logic       cordic_valid_o;
   logic [7:0] cordic_y_i;
   logic       cordic_done_i;
   logic [7:0] sample_o;
   logic       sample_valid_o;
   logic       busy_o;
   logic       overrun_o;
   logic       timeout_o;

   modport slave (
      input  sample_tick_i, enable_i, freq_word_i, phase_clear_i, clear_flags_i,
      input  cordic_y_i, cordic_done_i,
      output cordic_x_o, cordic_y_o, cordic_z_o, cordic_valid_o,
      output sample_o, sample_valid_o, busy_o, overrun_o, timeout_o
   );

   modport master (
      output sample_tick_i, enable_i, freq_word_i, phase_clear_i, clear_flags_i,
      output cordic_y_i, cordic_done_i,
      input  cordic_x_o, cordic_y_o, cordic_z_o, cordic_valid_o,
      input  sample_o, sample_valid_o, busy_o, overrun_o, timeout_o
   );

endinterface

// File: rtl/sine_phase_sequencer.sv
// Phase accumulator feeding one CORDIC request per accepted tick; sample 8 cycles after the tick.
// No backpressure: ticks arriving while busy are dropped and flagged as overrun.
module sine_phase_sequencer
   import sine_phase_sequencer_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   sine_phase_sequencer_if.slave bus
);

   logic [1:0]       state;
   logic [ACC_W-1:0] phase_acc;
   logic [3:0]       wait_cnt;
   logic [3:0]       wait_cnt_nxt;
   logic [7:0]       x_q;
   logic [7:0]       y_q;
   logic [7:0]       z_q;
   logic [7:0]       sample_q;
   logic             sample_vld_q;
   logic             overrun_q;
   logic             timeout_q;

   logic             tick_req;
   logic             accept;
   logic             drop;
   logic             timed_out;
   logic [7:0]       p;

   assign tick_req     = bus.sample_tick_i & bus.enable_i;
   assign accept       = tick_req & (state == ST_IDLE);
   assign drop         = tick_req & (state != ST_IDLE);
   assign wait_cnt_nxt = wait_cnt + 4'd1;
   assign timed_out    = (state == ST_WAIT) & ~bus.cordic_done_i & (wait_cnt_nxt == TIMEOUT_LIMIT);
   // A clear in the acceptance cycle also zeroes the captured phase.
   assign p            = bus.phase_clear_i ? 8'd0 : phase_acc[ACC_W-1 -: 8];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state        <= ST_IDLE;
         phase_acc    <= '0;
         wait_cnt     <= '0;
         x_q          <= '0;
         y_q          <= '0;
         z_q          <= '0;
         sample_q     <= '0;
         sample_vld_q <= 1'b0;
         overrun_q    <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         sample_vld_q <= 1'b0;

         if (bus.phase_clear_i) begin
            phase_acc <= '0;
         end else if (accept) begin
            phase_acc <= phase_acc + bus.freq_word_i;
         end

         case (state)
            ST_IDLE: begin
               if (accept) begin
                  state <= ST_ISSUE;
                  x_q   <= X_GAIN;
                  y_q   <= 8'd0;
                  z_q   <= fold_phase(p);
               end
            end
            ST_ISSUE: begin
               state    <= ST_WAIT;
               wait_cnt <= '0;
            end
            ST_WAIT: begin
               if (bus.cordic_done_i) begin
                  state        <= ST_IDLE;
                  sample_q     <= bus.cordic_y_i;
                  sample_vld_q <= 1'b1;
               end else if (timed_out) begin
                  state <= ST_IDLE;
               end else begin
                  wait_cnt <= wait_cnt_nxt;
               end
            end
            default: state <= ST_IDLE;
         endcase

         overrun_q <= drop | (overrun_q & ~bus.clear_flags_i);
         timeout_q <= timed_out | (timeout_q & ~bus.clear_flags_i);
      end
   end

   assign bus.cordic_x_o     = x_q;
   assign bus.cordic_y_o     = y_q;
   assign bus.cordic_z_o     = z_q;
   assign bus.cordic_valid_o = (state == ST_ISSUE);
   assign bus.sample_o       = sample_q;
   assign bus.sample_valid_o = sample_vld_q;
   assign bus.busy_o         = (state != ST_IDLE);
   assign bus.overrun_o      = overrun_q;
   assign bus.timeout_o      = timeout_q;

endmodule

// File: tb/tb_sine_phase_sequencer.sv
// Directed bench with a CORDIC stand-in: expectations are queued at stimulus time
// and a negedge monitor checks every cordic_valid_o and sample_valid_o against them.
module tb_sine_phase_sequencer;

   typedef struct {
      int val;
      int tol;
      int cyc;
   } samp_t;

   logic clk_i;
   logic rst_i;
   sine_phase_sequencer_if bus();

   sine_phase_sequencer dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    valid_cnt = 0;
   int    stub_cnt = 0;
   bit    stub_en = 1'b1;
   int    z_q[$];
   samp_t s_q[$];

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   // Stand-in CORDIC response: near-full-scale at +/-pi/2, small offset at 0, identity elsewhere.
   function automatic int stub_y(input int z);
      if (z == 64)  return 126;
      if (z == -64) return -126;
      if (z == 0)   return 1;
      return z;
   endfunction

   // Done is raised for the cycle sampled by the 7th edge after the ISSUE cycle.
   always @(negedge clk_i) begin
      bus.cordic_done_i = 1'b0;
      if (stub_cnt != 0) begin
         stub_cnt--;
         if (stub_cnt == 0 && stub_en) begin
            bus.cordic_done_i = 1'b1;
            bus.cordic_y_i    = 8'(stub_y(int'($signed(bus.cordic_z_o))));
         end
      end
      if (bus.cordic_valid_o) stub_cnt = 7;
   end

   always @(negedge clk_i) begin
      if (rst_i) begin
         if (bus.cordic_valid_o) begin
            valid_cnt++;
            if (z_q.size() == 0) begin
               check("unexpected_cordic_valid", 1, 0);
            end else begin
               check("cordic_z", int'($signed(bus.cordic_z_o)), z_q.pop_front());
               check("cordic_x", int'($signed(bus.cordic_x_o)), 77);
               check("cordic_y", int'($signed(bus.cordic_y_o)), 0);
            end
         end
         if (bus.sample_valid_o) begin
            if (s_q.size() == 0) begin
               check("unexpected_sample_valid", 1, 0);
            end else begin
               samp_t e;
               int    d;
               e = s_q.pop_front();
               d = int'($signed(bus.sample_o)) - e.val;
               if (d < 0) d = -d;
               checks++;
               if (d > e.tol) begin
                  errors++;
                  $display("FAIL sample_value actual %0d required %0d +/- %0d",
                           int'($signed(bus.sample_o)), e.val, e.tol);
               end
               check("sample_latency", cyc, e.cyc);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int z_exp, input bit acc, input bit samp,
                       input int ideal, input int tol, input bit clr);
      @(negedge clk_i);
      if (acc) begin
         z_q.push_back(z_exp);
         if (samp) s_q.push_back('{ideal, tol, cyc + 9});
      end
      bus.sample_tick_i = 1'b1;
      bus.phase_clear_i = clr;
      @(negedge clk_i);
      bus.sample_tick_i = 1'b0;
      bus.phase_clear_i = 1'b0;
   endtask

   task automatic tick_std(input int z_exp);
      tick(z_exp, 1'b1, 1'b1, stub_y(z_exp), 0, 1'b0);
      repeat (10) @(negedge clk_i);
   endtask

   task automatic pulse_phase_clear();
      @(negedge clk_i);
      bus.phase_clear_i = 1'b1;
      @(negedge clk_i);
      bus.phase_clear_i = 1'b0;
   endtask

   task automatic pulse_clear_flags();
      @(negedge clk_i);
      bus.clear_flags_i = 1'b1;
      @(negedge clk_i);
      bus.clear_flags_i = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_x"}, int'(bus.cordic_x_o), 0);
      check({tag, "_z"}, int'(bus.cordic_z_o), 0);
      check({tag, "_sample"}, int'(bus.sample_o), 0);
      check({tag, "_flags"}, int'({bus.cordic_y_o != 8'd0, bus.cordic_valid_o, bus.sample_valid_o,
                                   bus.busy_o, bus.overrun_o, bus.timeout_o}), 0);
   endtask

   initial begin
      int sweep_z[4]  = '{0, 64, 0, -64};
      int sweep_s[4]  = '{0, 127, 0, -127};
      int fold_p[7]   = '{63, 64, 127, 128, 191, 192, 255};
      int fold_z[7]   = '{63, 64, 1, 0, -63, -64, -1};
      int n;
      int vbefore;

      rst_i             = 1'b0;
      bus.sample_tick_i = 1'b0;
      bus.enable_i      = 1'b1;
      bus.freq_word_i   = 16'h0000;
      bus.phase_clear_i = 1'b0;
      bus.clear_flags_i = 1'b0;
      repeat (3) @(negedge clk_i);
      check_all_zero("reset_init");
      rst_i = 1'b1;

      // Quarter-turn sweep
      bus.freq_word_i = 16'h4000;
      for (int i = 0; i < 4; i++) begin
         tick(sweep_z[i], 1'b1, 1'b1, sweep_s[i], 4, 1'b0);
         repeat (10) @(negedge clk_i);
      end

      // Fold boundaries: load phase p<<8 then tick on it
      for (int i = 0; i < 7; i++) begin
         pulse_phase_clear();
         bus.freq_word_i = 16'(fold_p[i] << 8);
         tick_std(0);
         tick_std(fold_z[i]);
      end

      // Clear together with a tick: p = 0 and the accumulator restarts from 0
      bus.freq_word_i = 16'h1234;
      tick(0, 1'b1, 1'b1, stub_y(0), 0, 1'b1);
      repeat (10) @(negedge clk_i);
      tick_std(0);
      tick_std(18);

      // Enable low: ticks ignored, no overrun, accumulator held at 0x2468
      bus.enable_i = 1'b0;
      vbefore = valid_cnt;
      for (int i = 0; i < 3; i++) begin
         tick(0, 1'b0, 1'b0, 0, 0, 1'b0);
         repeat (3) @(negedge clk_i);
      end
      check("disabled_valid_count", valid_cnt, vbefore);
      check("disabled_overrun", int'(bus.overrun_o), 0);
      bus.enable_i = 1'b1;
      tick_std(36);

      // Overrun: second tick 3 cycles after the first is dropped
      pulse_phase_clear();
      bus.freq_word_i = 16'h0100;
      tick(0, 1'b1, 1'b1, stub_y(0), 0, 1'b0);
      @(negedge clk_i);
      tick(0, 1'b0, 1'b0, 0, 0, 1'b0);
      repeat (10) @(negedge clk_i);
      check("overrun_set", int'(bus.overrun_o), 1);
      tick_std(1);

      // Clear-flags loses against a simultaneous overrun event
      pulse_clear_flags();
      check("overrun_cleared", int'(bus.overrun_o), 0);
      tick(2, 1'b1, 1'b1, stub_y(2), 0, 1'b0);
      @(negedge clk_i);
      bus.sample_tick_i = 1'b1;
      bus.clear_flags_i = 1'b1;
      @(negedge clk_i);
      bus.sample_tick_i = 1'b0;
      bus.clear_flags_i = 1'b0;
      check("overrun_wins_clear", int'(bus.overrun_o), 1);
      repeat (10) @(negedge clk_i);

      // Timeout with a silent CORDIC
      pulse_clear_flags();
      stub_en = 1'b0;
      tick(3, 1'b1, 1'b0, 0, 0, 1'b0);
      n = 0;
      while (bus.busy_o && n < 40) begin
         n++;
         @(negedge clk_i);
      end
      check("timeout_busy_cycles", n, 16);
      check("timeout_flag", int'(bus.timeout_o), 1);
      check("timeout_sample_held", int'($signed(bus.sample_o)), 2);
      stub_en = 1'b1;
      repeat (4) @(negedge clk_i);
      tick_std(4);

      // Reset mid-WAIT: outputs drop at once, late done ignored
      tick(5, 1'b1, 1'b1, stub_y(5), 0, 1'b0);
      repeat (3) @(negedge clk_i);
      #2 rst_i = 1'b0;
      #1 check_all_zero("reset_mid");
      s_q.delete();
      repeat (2) @(negedge clk_i);
      rst_i = 1'b1;
      repeat (12) @(negedge clk_i);
      tick_std(0);

      repeat (4) @(negedge clk_i);
      check("z_queue_drained", z_q.size(), 0);
      check("sample_queue_drained", s_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
